// File: rtl/render_frame_scheduler_pkg.sv
// Shared types and defaults for the RendererV3 frame scheduler.
// Defaults assume a 640x480 screen carved into 32x32 pixel tiles.
package render_pkg;

    localparam int unsigned TILE_PX     = 32;
    localparam int unsigned DEF_TILES_X = 640 / TILE_PX;
    localparam int unsigned DEF_TILES_Y = 480 / TILE_PX;

    // Counter width that stays legal (>= 1 bit) for degenerate sizes.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned TILE_X_W = cnt_width(DEF_TILES_X);
    localparam int unsigned TILE_Y_W = cnt_width(DEF_TILES_Y);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VSYNC,
        DISPATCH,
        DRAIN,
        WAIT_FLIP
    } FrameSchedState_t;

    typedef struct packed {
        logic [TILE_X_W-1:0] tile_x;
        logic [TILE_Y_W-1:0] tile_y;
    } tile_coord_t;

endpackage

// File: rtl/render_frame_scheduler_tile_walker.sv
// Raster-order tile coordinate counter: x runs fastest, wraps into y.
// o_last flags the final tile of the screen.
module tile_walker
    import render_pkg::*;
#(
    parameter int unsigned TILES_X = DEF_TILES_X,
    parameter int unsigned TILES_Y = DEF_TILES_Y
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            i_clear,
    input  logic                            i_advance,
    output logic [cnt_width(TILES_X)-1:0]   o_tile_x,
    output logic [cnt_width(TILES_Y)-1:0]   o_tile_y,
    output logic                            o_last
);

    localparam int unsigned XW = cnt_width(TILES_X);
    localparam int unsigned YW = cnt_width(TILES_Y);
    localparam logic [XW-1:0] X_LAST = XW'(TILES_X - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(TILES_Y - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_x_last;
    logic          w_y_last;

    assign w_x_last = (r_x == X_LAST);
    assign w_y_last = (r_y == Y_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_tile_x = r_x;
    assign o_tile_y = r_y;
    assign o_last   = w_x_last & w_y_last;

endmodule

// File: rtl/render_frame_scheduler.sv
// Sequences one frame per display refresh: waits for vsync, streams every tile to the
// render cores with a bounded number outstanding, drains, then flips on the next vsync.
module render_frame_scheduler
    import render_pkg::*;
#(
    parameter int unsigned TILES_X      = DEF_TILES_X,
    parameter int unsigned TILES_Y      = DEF_TILES_Y,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned FRAME_CNT_W  = 16
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            vsync,
    input  logic                            enable,
    output logic                            tile_valid,
    input  logic                            tile_ready,
    output logic [cnt_width(TILES_X)-1:0]   tile_x,
    output logic [cnt_width(TILES_Y)-1:0]   tile_y,
    input  logic                            tile_done,
    output logic                            frame_busy,
    output logic                            flip,
    output logic                            back_buffer,
    output logic [FRAME_CNT_W-1:0]          frame_count,
    output logic                            overrun,
    output logic                            done_error
);

    localparam int unsigned IW = cnt_width(MAX_INFLIGHT + 1);
    localparam logic [IW-1:0] INFLIGHT_MAX = IW'(MAX_INFLIGHT);

    FrameSchedState_t       r_state;
    logic                   r_vsync_q;
    logic [IW-1:0]          r_inflight;
    logic                   r_busy;
    logic                   r_flip;
    logic                   r_back_buffer;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    logic                   r_overrun;
    logic                   r_done_error;

    logic                   w_vsync_edge;
    logic                   w_accept;
    logic                   w_clear;
    logic                   w_last;

    assign w_vsync_edge = vsync & ~r_vsync_q;
    assign tile_valid   = (r_state == DISPATCH) && (r_inflight < INFLIGHT_MAX);
    assign w_accept     = tile_valid & tile_ready;
    // Raster restarts whenever a frame is launched, whether from idle or back-to-back.
    assign w_clear      = w_vsync_edge && enable &&
                          ((r_state == WAIT_VSYNC) || (r_state == WAIT_FLIP));

    tile_walker #(
        .TILES_X (TILES_X),
        .TILES_Y (TILES_Y)
    ) u_tile_walker (
        .clk       (clk),
        .resetn    (resetn),
        .i_clear   (w_clear),
        .i_advance (w_accept),
        .o_tile_x  (tile_x),
        .o_tile_y  (tile_y),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_vsync_q     <= 1'b1;
            r_inflight    <= '0;
            r_busy        <= 1'b0;
            r_flip        <= 1'b0;
            r_back_buffer <= 1'b0;
            r_frame_count <= '0;
            r_overrun     <= 1'b0;
            r_done_error  <= 1'b0;
        end else begin
            r_vsync_q <= vsync;
            r_flip    <= 1'b0;

            if (w_accept && !tile_done) begin
                r_inflight <= r_inflight + 1'b1;
            end else if (!w_accept && tile_done && (r_inflight != '0)) begin
                r_inflight <= r_inflight - 1'b1;
            end
            if (tile_done && (r_inflight == '0)) begin
                r_done_error <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (enable) r_state <= WAIT_VSYNC;
                end
                WAIT_VSYNC: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (w_vsync_edge) begin
                        r_state <= DISPATCH;
                        r_busy  <= 1'b1;
                    end
                end
                DISPATCH: begin
                    if (w_vsync_edge) r_overrun <= 1'b1;
                    if (w_accept && w_last) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (w_vsync_edge) r_overrun <= 1'b1;
                    if (r_inflight == '0) begin
                        r_state <= WAIT_FLIP;
                        r_busy  <= 1'b0;
                    end
                end
                WAIT_FLIP: begin
                    if (w_vsync_edge) begin
                        r_flip        <= 1'b1;
                        r_back_buffer <= ~r_back_buffer;
                        r_frame_count <= r_frame_count + 1'b1;
                        if (enable) begin
                            r_state <= DISPATCH;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign frame_busy  = r_busy;
    assign flip        = r_flip;
    assign back_buffer = r_back_buffer;
    assign frame_count = r_frame_count;
    assign overrun     = r_overrun;
    assign done_error  = r_done_error;

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Scoreboard bench for render_frame_scheduler on a 2x2 tile screen with two tiles in flight.
module tb_render_frame_scheduler;

    localparam int unsigned TX = 2;
    localparam int unsigned TY = 2;
    localparam int unsigned MI = 2;
    localparam int unsigned FW = 16;
    localparam int unsigned XW = $clog2(TX);
    localparam int unsigned YW = $clog2(TY);

    logic          clk = 1'b0;
    logic          resetn;
    logic          vsync;
    logic          enable;
    logic          tile_ready;
    logic          tile_done;
    logic          manual_done;
    logic          auto_done;
    logic          tile_valid;
    logic [XW-1:0] tile_x;
    logic [YW-1:0] tile_y;
    logic          frame_busy;
    logic          flip;
    logic          back_buffer;
    logic [FW-1:0] frame_count;
    logic          overrun;
    logic          done_error;

    int            n_checks = 0;
    int            n_errors = 0;
    int            flip_cnt = 0;
    logic [31:0]   tile_q[$];
    logic [31:0]   flip_q[$];
    logic [3:0]    done_sr;

    assign tile_done = auto_done | manual_done;

    always #5 clk = ~clk;

    render_frame_scheduler #(
        .TILES_X      (TX),
        .TILES_Y      (TY),
        .MAX_INFLIGHT (MI),
        .FRAME_CNT_W  (FW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .vsync       (vsync),
        .enable      (enable),
        .tile_valid  (tile_valid),
        .tile_ready  (tile_ready),
        .tile_x      (tile_x),
        .tile_y      (tile_y),
        .tile_done   (tile_done),
        .frame_busy  (frame_busy),
        .flip        (flip),
        .back_buffer (back_buffer),
        .frame_count (frame_count),
        .overrun     (overrun),
        .done_error  (done_error)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int y = 0; y < int'(TY); y++)
            for (int x = 0; x < int'(TX); x++)
                tile_q.push_back(32'((y << 8) | x));
    endtask

    // Low then high; returns 1ns after the edge in which the edge is acted on.
    task automatic vsync_pulse();
        vsync = 1'b0;
        tick(1);
        vsync = 1'b1;
        tick(1);
    endtask

    task automatic wait_busy_low(input int budget);
        for (int i = 0; i < budget && frame_busy; i++) tick(1);
        check_eq("busy_drop_timeout", 32'(frame_busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(tile_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(frame_busy), 32'd0);
        check_eq({tag, "_flip"}, 32'(flip), 32'd0);
        check_eq({tag, "_bb"}, 32'(back_buffer), 32'd0);
        check_eq({tag, "_fc"}, 32'(frame_count), 32'd0);
        check_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
        check_eq({tag, "_done_err"}, 32'(done_error), 32'd0);
        check_eq({tag, "_x"}, 32'(tile_x), 32'd0);
        check_eq({tag, "_y"}, 32'(tile_y), 32'd0);
    endtask

    // Output monitor: pops tile and flip expectations, and models cores finishing tiles.
    initial begin : monitor
        logic        acc;
        logic [31:0] exp_v;
        done_sr   = '0;
        auto_done = 1'b0;
        forever begin
            @(negedge clk);
            acc = resetn && tile_valid && tile_ready;
            if (acc) begin
                if (tile_q.size() == 0) begin
                    check_eq("tile_extra", (32'(tile_y) << 8) | 32'(tile_x), 32'hFFFF_FFFF);
                end else begin
                    exp_v = tile_q.pop_front();
                    check_eq("tile_xy", (32'(tile_y) << 8) | 32'(tile_x), exp_v);
                end
            end
            if (flip) begin
                flip_cnt++;
                if (flip_q.size() == 0) begin
                    check_eq("flip_extra", 32'(frame_count), 32'hFFFF_FFFF);
                end else begin
                    exp_v = flip_q.pop_front();
                    check_eq("flip_state", (32'(back_buffer) << 16) | 32'(frame_count), exp_v);
                end
            end
            done_sr   = {done_sr[2:0], acc};
            auto_done = done_sr[3];
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin : stimulus
        resetn      = 1'b0;
        vsync       = 1'b1;
        enable      = 1'b1;
        tile_ready  = 1'b1;
        manual_done = 1'b0;
        tick(2);
        check_reset_outputs("rst");
        resetn = 1'b1;

        // vsync high since reset must not count as an edge.
        tick(5);
        check_eq("no_edge_valid", 32'(tile_valid), 32'd0);
        check_eq("no_edge_busy", 32'(frame_busy), 32'd0);

        // Frame 1.
        push_frame();
        vsync_pulse();
        check_eq("f1_valid", 32'(tile_valid), 32'd1);
        check_eq("f1_x0", 32'(tile_x), 32'd0);
        check_eq("f1_y0", 32'(tile_y), 32'd0);
        check_eq("f1_busy", 32'(frame_busy), 32'd1);
        tick(2);
        check_eq("f1_throttle", 32'(tile_valid), 32'd0);
        tick(2);
        check_eq("f1_resume_valid", 32'(tile_valid), 32'd1);
        check_eq("f1_resume_y", 32'(tile_y), 32'd1);
        wait_busy_low(40);
        check_eq("f1_drained_valid", 32'(tile_valid), 32'd0);
        check_eq("f1_tiles_left", 32'(tile_q.size()), 32'd0);
        check_eq("f1_no_flip", 32'(flip_cnt), 32'd0);

        // Flip into frame 2, then stall the cores.
        flip_q.push_back(32'((1 << 16) | 1));
        push_frame();
        vsync_pulse();
        check_eq("flip1", 32'(flip), 32'd1);
        check_eq("flip1_bb", 32'(back_buffer), 32'd1);
        check_eq("flip1_fc", 32'(frame_count), 32'd1);
        check_eq("f2_valid", 32'(tile_valid), 32'd1);
        check_eq("f2_busy", 32'(frame_busy), 32'd1);
        tile_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_eq("stall_valid", 32'(tile_valid), 32'd1);
            check_eq("stall_xy", (32'(tile_y) << 8) | 32'(tile_x), 32'd0);
        end
        check_eq("flip1_one_cycle", 32'(flip_cnt), 32'd1);
        tile_ready = 1'b1;
        tick(2);
        check_eq("f2_throttle", 32'(tile_valid), 32'd0);
        tick(4);
        check_eq("f2_drain_busy", 32'(frame_busy), 32'd1);
        check_eq("f2_drain_valid", 32'(tile_valid), 32'd0);
        check_eq("f2_overrun_pre", 32'(overrun), 32'd0);

        // vsync during DRAIN: overrun, no flip.
        vsync_pulse();
        check_eq("overrun_set", 32'(overrun), 32'd1);
        check_eq("overrun_no_flip", 32'(flip), 32'd0);
        check_eq("overrun_busy", 32'(frame_busy), 32'd1);
        wait_busy_low(40);
        check_eq("overrun_sticky", 32'(overrun), 32'd1);
        check_eq("overrun_fc", 32'(frame_count), 32'd1);

        // Flip with enable low ends in IDLE.
        enable = 1'b0;
        flip_q.push_back(32'((0 << 16) | 2));
        vsync_pulse();
        check_eq("flip2", 32'(flip), 32'd1);
        check_eq("flip2_bb", 32'(back_buffer), 32'd0);
        check_eq("flip2_fc", 32'(frame_count), 32'd2);
        check_eq("flip2_valid", 32'(tile_valid), 32'd0);
        check_eq("flip2_busy", 32'(frame_busy), 32'd0);
        tick(1);
        check_eq("flip2_pulse_end", 32'(flip), 32'd0);
        vsync_pulse();
        tick(2);
        check_eq("idle_valid", 32'(tile_valid), 32'd0);
        check_eq("idle_busy", 32'(frame_busy), 32'd0);

        // Spurious completion with nothing outstanding.
        check_eq("done_err_pre", 32'(done_error), 32'd0);
        manual_done = 1'b1;
        tick(1);
        manual_done = 1'b0;
        check_eq("done_err_set", 32'(done_error), 32'd1);

        // Reset in the middle of DISPATCH.
        tile_ready = 1'b0;
        enable     = 1'b1;
        tick(1);
        vsync_pulse();
        check_eq("f3_valid", 32'(tile_valid), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        tick(2);
        resetn     = 1'b1;
        tile_ready = 1'b1;
        tick(4);
        check_eq("post_rst_valid", 32'(tile_valid), 32'd0);
        check_eq("post_rst_busy", 32'(frame_busy), 32'd0);

        check_eq("end_tiles_left", 32'(tile_q.size()), 32'd0);
        check_eq("end_flips_left", 32'(flip_q.size()), 32'd0);
        check_eq("end_flip_cnt", 32'(flip_cnt), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
